// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480@60 Hz VGA timing generator and pixel sink.
// A free-running horizontal/vertical counter pair defines the raster. Pixel
// coordinates are requested one clock ahead of the visible window so that a
// combinational renderer's answer can be registered into vga_rgb and land
// exactly on the visible pixel. hsync/vsync come straight from the counters.
// frame_start marks counter position (0,0); vblank_tick marks the first
// front-porch line and is the safe point for game-state updates.

module vga_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_data_req,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] vga_rgb,
    output logic        frame_start,
    output logic        vblank_tick,
    output logic [15:0] frame_cnt
);

    // Totals must fit the 10-bit counters (<= 1024).
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);

    // Requests lead the visible columns by one clock to cover the output register.
    localparam logic [9:0] H_REQ_FIRST = 10'(H_SYNC + H_BP - 1);
    localparam logic [9:0] H_REQ_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE - 2);
    localparam logic [9:0] V_ACT_FIRST = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    localparam logic [9:0] NO_REQ      = 10'h3FF;

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       h_end;
    logic       v_end;
    logic       req_h;
    logic       req_v;
    logic       req;
    logic       vblank_hit;

    // Raster position decode shared by the counters, syncs and tick logic.
    always_comb begin
        h_end      = (cnt_h == H_LAST);
        v_end      = (cnt_v == V_LAST);
        req_h      = (cnt_h >= H_REQ_FIRST) && (cnt_h <= H_REQ_LAST);
        req_v      = (cnt_v >= V_ACT_FIRST) && (cnt_v <= V_ACT_LAST);
        req        = req_h && req_v;
        vblank_hit = h_end && (cnt_v == V_ACT_LAST);
    end

    // Horizontal counter: one step per pixel clock, wraps at end of line.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            cnt_h <= '0;
        end else if (h_end) begin
            cnt_h <= '0;
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    // Vertical counter: one step per line, wraps at end of frame.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            cnt_v <= '0;
        end else if (h_end) begin
            if (v_end) begin
                cnt_v <= '0;
            end else begin
                cnt_v <= cnt_v + 10'd1;
            end
        end
    end

    // Sync pulses sit at the start of each line/frame; both active-low.
    always_comb begin
        hsync = (cnt_h >= H_SYNC_END);
        vsync = (cnt_v >= V_SYNC_END);
    end

    // Coordinate request toward the renderer; all-ones when idle.
    always_comb begin
        pix_data_req = req;
        pix_x        = NO_REQ;
        pix_y        = NO_REQ;
        if (req) begin
            pix_x = cnt_h - H_REQ_FIRST;
            pix_y = cnt_v - V_ACT_FIRST;
        end
    end

    // Capture the renderer's answer; blank everywhere outside the window.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            vga_rgb <= '0;
        end else if (req) begin
            vga_rgb <= pix_data;
        end else begin
            vga_rgb <= '0;
        end
    end

    // Frame-level strobes, registered so they are high at (0,0) and the
    // first front-porch line respectively.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            frame_start <= 1'b0;
            vblank_tick <= 1'b0;
        end else begin
            frame_start <= h_end && v_end;
            vblank_tick <= vblank_hit;
        end
    end

    // Frame counter advances with each vblank_tick and wraps naturally.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            frame_cnt <= '0;
        end else if (vblank_hit) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule
